// File: rtl/uart_tx_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants, FSM state type and divisor helpers for uart_tx_cfg.
// Revision: 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_parity_none = 0;
    localparam int c_parity_odd  = 1;
    localparam int c_parity_even = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // The divisor must be exact; a rounded baud rate would drift over a frame.
    function automatic bit div_ok(input int clk_hz, input int baud);
        return (baud > 0) && (clk_hz >= baud) && ((clk_hz % baud) == 0);
    endfunction

    function automatic int calc_div(input int clk_hz, input int baud);
        return (baud > 0) ? (clk_hz / baud) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg_if
// Brief   : Producer-side handshake and line/status signals of uart_tx_cfg.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_tx_cfg_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]                 tx_data;
    logic                                 tx_valid;
    logic                                 tx_ready;
    logic                                 out;
    logic                                 busy;
    logic [$clog2(FIFO_DEPTH + 1)-1:0]    fifo_level;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  out,
        input  busy,
        input  fifo_level
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output out,
        output busy,
        output fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock first-word-fall-through FIFO with occupancy output.
// Revision: 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           push,
    input  wire logic [WIDTH-1:0]               wdata,
    input  wire logic                           pop,
    output      logic [WIDTH-1:0]               rdata,
    output      logic                           full,
    output      logic                           empty,
    output      logic [$clog2(DEPTH + 1)-1:0]   level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign full   = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign level  = c_lw'(r_wr_ptr - r_rd_ptr);
    assign rdata  = r_mem[r_rd_ptr[c_aw-1:0]];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Configurable UART transmitter with input FIFO and zero-gap framing.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 9600,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_tx_cfg_if.slave  bus
);

    localparam int                 c_div       = calc_div(CLK_HZ, BAUD);
    localparam int                 c_cnt_w     = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int                 c_lvl_w     = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(c_div - 1);
    localparam logic [3:0]         c_data_last = 4'(DATA_BITS - 1);
    localparam logic [3:0]         c_stop_last = 4'(STOP_BITS - 1);
    localparam bit                 c_has_par   = (PARITY != c_parity_none);
    localparam bit                 c_odd_par   = (PARITY == c_parity_odd);

    if (!div_ok(CLK_HZ, BAUD)) begin : g_bad_div
        $error("uart_tx_cfg: CLK_HZ must be a nonzero exact multiple of BAUD");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be within 5..9");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [c_cnt_w-1:0]     r_baud;
    logic [3:0]             r_bit;
    logic [3:0]             w_bit_nxt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par;
    logic                   r_out;
    logic                   w_out_nxt;
    logic                   w_tick;
    logic                   w_pop;
    logic                   w_shift_en;
    logic [DATA_BITS-1:0]   w_fifo_rdata;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [c_lvl_w-1:0]     w_fifo_level;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.tx_valid),
        .wdata (bus.tx_data),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    assign w_tick         = (r_baud == c_baud_last);
    assign bus.tx_ready   = !w_fifo_full;
    assign bus.out        = r_out;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.fifo_level = w_fifo_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_pop       = 1'b0;
        w_shift_en  = 1'b0;
        w_out_nxt   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_out_nxt = 1'b0;
                if (w_tick) begin
                    w_bit_nxt   = 4'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                w_out_nxt = r_shift[0];
                if (w_tick) begin
                    w_shift_en = 1'b1;
                    if (r_bit == c_data_last) begin
                        w_bit_nxt   = 4'd0;
                        w_state_nxt = c_has_par ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                w_out_nxt = r_par;
                if (w_tick) begin
                    w_bit_nxt   = 4'd0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_bit == c_stop_last) begin
                        // Chain straight into the next start bit when data is waiting.
                        w_bit_nxt = 4'd0;
                        if (!w_fifo_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_START;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud  <= '0;
            r_bit   <= 4'd0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_out   <= 1'b1;
        end else begin
            r_bit <= w_bit_nxt;
            r_out <= w_out_nxt;
            if ((r_state == ST_IDLE) || w_tick) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (w_pop) begin
                r_shift <= w_fifo_rdata;
                r_par   <= (^w_fifo_rdata) ^ c_odd_par;
            end else if (w_shift_en) begin
                r_shift <= r_shift >> 1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Four-configuration bench for uart_tx_cfg against a line-timeline model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int NCFG = 4;
    localparam int C_CLK   [NCFG] = '{38400, 38400, 9600, 19200};
    localparam int C_BAUD  [NCFG] = '{9600, 9600, 9600, 9600};
    localparam int C_DIV   [NCFG] = '{4, 4, 1, 2};
    localparam int C_DB    [NCFG] = '{8, 8, 7, 9};
    localparam int C_PAR   [NCFG] = '{0, 2, 0, 1};
    localparam int C_STOP  [NCFG] = '{1, 1, 2, 2};
    localparam int C_DEPTH [NCFG] = '{4, 4, 4, 8};
    localparam int C_LEN   [NCFG] = '{40, 44, 10, 26};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] tx_data  [NCFG];
    logic       tx_valid [NCFG];
    logic       o_out    [NCFG];
    logic       o_busy   [NCFG];
    logic       o_ready  [NCFG];
    logic [3:0] o_level  [NCFG];

    int unsigned mq [NCFG][$];
    bit          ml [NCFG][$];
    int          mrem    [NCFG];
    logic        e_out   [NCFG];
    logic        e_busy  [NCFG];
    logic        e_ready [NCFG];
    logic [3:0]  e_level [NCFG];

    logic ws [NCFG][60];
    logic bs [NCFG][60];

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        uart_tx_cfg_if #(.DATA_BITS(C_DB[gi]), .FIFO_DEPTH(C_DEPTH[gi])) bus ();
        assign bus.tx_data  = tx_data[gi][C_DB[gi]-1:0];
        assign bus.tx_valid = tx_valid[gi];
        assign o_out[gi]    = bus.out;
        assign o_busy[gi]   = bus.busy;
        assign o_ready[gi]  = bus.tx_ready;
        assign o_level[gi]  = 4'(bus.fifo_level);
        uart_tx_cfg #(
            .CLK_HZ     (C_CLK[gi]),
            .BAUD       (C_BAUD[gi]),
            .DATA_BITS  (C_DB[gi]),
            .PARITY     (C_PAR[gi]),
            .STOP_BITS  (C_STOP[gi]),
            .FIFO_DEPTH (C_DEPTH[gi])
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", name, idx, act, exp, $time);
    endtask

    // Line level of bit slot k of a frame carrying word w on configuration i.
    function automatic bit frame_bit(input int i, input int unsigned w, input int k);
        bit p;
        if (k == 0) return 1'b0;
        if (k <= C_DB[i]) return bit'((w >> (k - 1)) & 1);
        if ((k == C_DB[i] + 1) && (C_PAR[i] != 0)) begin
            p = ($countones(w) % 2) == 1;
            return (C_PAR[i] == 1) ? !p : p;
        end
        return 1'b1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + C_DB[i] + ((C_PAR[i] != 0) ? 1 : 0) + C_STOP[i]) * C_DIV[i];
    endfunction

    // Timeline model: queue of accepted words plus queue of future line samples.
    always @(posedge clk) begin : p_model
        bit          acc;
        bit          pop;
        int unsigned w;
        for (int i = 0; i < NCFG; i++) begin
            if (rst) begin
                mq[i].delete();
                ml[i].delete();
                mrem[i] = 0;
                e_out[i] = 1'b1;
            end else begin
                acc = tx_valid[i] && (mq[i].size() < C_DEPTH[i]);
                pop = (mq[i].size() != 0) && (mrem[i] <= 1);
                e_out[i] = (ml[i].size() != 0) ? ml[i].pop_front() : 1'b1;
                if (pop) begin
                    w = mq[i].pop_front();
                    for (int k = 0; k < frame_len(i) / C_DIV[i]; k++)
                        for (int d = 0; d < C_DIV[i]; d++)
                            ml[i].push_back(frame_bit(i, w, k));
                    mrem[i] = frame_len(i);
                end else if (mrem[i] > 0) begin
                    mrem[i]--;
                end
                if (acc) mq[i].push_back(int'(tx_data[i]) & ((1 << C_DB[i]) - 1));
            end
            e_busy[i]  = (mrem[i] > 0);
            e_ready[i] = (mq[i].size() < C_DEPTH[i]);
            e_level[i] = 4'(mq[i].size());
        end
    end

    always @(negedge clk) begin : p_compare
        if (chk_en) begin
            for (int i = 0; i < NCFG; i++) begin
                check("out", i, o_out[i], e_out[i]);
                check("busy", i, o_busy[i], e_busy[i]);
                check("tx_ready", i, o_ready[i], e_ready[i]);
                check("fifo_level", i, o_level[i], e_level[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit any_active();
        for (int i = 0; i < NCFG; i++)
            if (o_busy[i] || (o_level[i] != 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (any_active() && (n < 3000)) begin
            step();
            n++;
        end
        @(negedge clk);
        check(name, 0, any_active(), 0);
    endtask

    initial begin : p_main
        logic [9:0] pat0;
        logic [9:0] pat2;
        int         cnt;
        int         mis;
        int         acc0;
        logic       rdy6;
        int         thr;
        pat0 = 10'b1101001010;
        pat2 = 10'b1110101010;
        for (int i = 0; i < NCFG; i++) begin
            tx_data[i]  = '0;
            tx_valid[i] = 1'b0;
        end

        step();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out", 0, o_out[0], 1);
        check("rst_busy", 0, o_busy[0], 0);
        check("rst_ready", 0, o_ready[0], 1);
        check("rst_level", 0, o_level[0], 0);
        step();
        rst = 1'b0;
        repeat (3) step();

        // Single word per configuration, waveform captured from the push edge.
        for (int i = 0; i < NCFG; i++) begin
            tx_data[i]  = (i == 2) ? 9'h055 : 9'h0A5;
            tx_valid[i] = 1'b1;
        end
        step();
        for (int i = 0; i < NCFG; i++) tx_valid[i] = 1'b0;
        for (int s = 0; s < 60; s++) begin
            @(negedge clk);
            for (int i = 0; i < NCFG; i++) begin
                ws[i][s] = o_out[i];
                bs[i][s] = o_busy[i];
            end
        end
        for (int i = 0; i < NCFG; i++) begin
            cnt = 0;
            for (int s = 0; s < 60; s++) if (bs[i][s] === 1'b1) cnt++;
            check("busy_len", i, cnt, C_LEN[i]);
        end
        check("latency_hi", 0, ws[0][1], 1);
        check("latency_lo", 0, ws[0][2], 0);
        mis = 0;
        for (int k = 0; k < 40; k++) if (ws[0][2 + k] !== pat0[k / 4]) mis++;
        check("wave_8n1", 0, mis, 0);
        check("idle_after", 0, ws[0][42], 1);
        mis = 0;
        for (int k = 38; k < 42; k++) if (ws[1][k] !== 1'b0) mis++;
        check("even_parity", 1, mis, 0);
        check("even_stop", 1, ws[1][45], 1);
        mis = 0;
        for (int k = 0; k < 10; k++) if (ws[2][2 + k] !== pat2[k]) mis++;
        check("wave_div1", 2, mis, 0);
        check("odd_parity", 3, ws[3][22], 1);
        check("odd_parity2", 3, ws[3][23], 1);
        drain("drain_single");

        // Six-cycle burst from idle.
        acc0 = 0;
        rdy6 = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NCFG; i++) begin
                tx_data[i]  = 9'($urandom);
                tx_valid[i] = 1'b1;
            end
            @(negedge clk);
            if (o_ready[0]) acc0++;
            if (k == 5) rdy6 = o_ready[0];
            step();
        end
        for (int i = 0; i < NCFG; i++) tx_valid[i] = 1'b0;
        check("burst_accepted", 0, acc0, 5);
        check("burst_ready6", 0, rdy6, 0);
        drain("drain_burst");

        // Push coinciding with the zero-gap pop at level 2, then mid-DATA reset.
        step();
        for (int k = 0; k < 3; k++) begin
            tx_data[0]  = 9'(8'h10 + k);
            tx_valid[0] = 1'b1;
            step();
        end
        tx_valid[0] = 1'b0;
        repeat (38) step();
        @(negedge clk);
        check("level_before", 0, o_level[0], 2);
        tx_data[0]  = 9'h033;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        @(negedge clk);
        check("level_pushpop", 0, o_level[0], 2);
        tx_data[0]  = 9'h044;
        tx_valid[0] = 1'b1;
        step();
        tx_valid[0] = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_out", 0, o_out[0], 1);
        check("abort_level", 0, o_level[0], 0);
        check("abort_busy", 0, o_busy[0], 0);
        cnt = 0;
        for (int s = 0; s < 50; s++) begin
            @(negedge clk);
            if (o_out[0] !== 1'b1 || o_busy[0] !== 1'b0) cnt++;
        end
        check("abort_quiet", 0, cnt, 0);

        // Randomised traffic with varying load and rare resets.
        for (int seg = 0; seg < 8; seg++) begin
            thr = (seg % 4 == 0) ? 15 : (seg % 4 == 1) ? 50 : (seg % 4 == 2) ? 90 : 100;
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < NCFG; i++) begin
                    tx_data[i]  = 9'($urandom);
                    tx_valid[i] = ($urandom_range(0, 99) < thr);
                end
                rst = ($urandom_range(0, 999) == 0);
                step();
            end
        end
        for (int i = 0; i < NCFG; i++) tx_valid[i] = 1'b0;
        rst = 1'b0;
        drain("drain_random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter: successor to the fixed-format `uart_tx`, with configurable baud divisor, data width, parity and stop bits, plus an input FIFO behind a valid/ready handshake. It sits between on-chip producers (debug/logging logic) and the board's serial TX pin, driving `out` idle-high. Frames go out LSB first, back-to-back with no idle gap while the FIFO holds data.

## Interface

- `CLK_HZ`, 9600: clock frequency in Hz.
- `BAUD`, 9600: line rate. `DIV = CLK_HZ/BAUD`, integer, ≥1; elaboration error otherwise. Must not be rounded: `CLK_HZ` must be an exact multiple of `BAUD`.
- `DATA_BITS`, 8: payload bits per frame, 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: input FIFO entries, power of 2, ≥2.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_data` in DATA_BITS: word to send.
- `tx_valid` in 1: `tx_data` valid.
- `tx_ready` out 1: FIFO can accept; equals !full.
- `out` out 1: serial line, idle high.
- `busy` out 1: high while a frame is on the line (any state except IDLE).
- `fifo_level` out $clog2(FIFO_DEPTH+1): current FIFO occupancy.

## Operation

- Reset values: `out`=1, `busy`=0, `tx_ready`=1, `fifo_level`=0, state IDLE, baud/bit counters 0, FIFO pointers 0.
- Push on edge with `tx_valid && tx_ready`; `tx_data` latched. No push when full; `tx_valid` held by producer.
- States: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE or START.
- IDLE: if FIFO non-empty, pop into shift register, go START. Pop and push in same cycle both take effect; level unchanged.
- START: `out`=0 for DIV cycles.
- DATA: `out`=shift[0], shift right each bit; DATA_BITS bits, DIV cycles each.
- PARITY: `out`= XOR of payload (even), its inverse (odd); computed at pop time.
- STOP: `out`=1 for STOP_BITS×DIV cycles. On its last cycle: if FIFO non-empty, pop and go START (zero-gap); else IDLE.
- Baud counter counts 0..DIV-1, bit advances when it reaches DIV-1; DIV=1 means one bit per clock.
- `rst` mid-frame: frame aborted, `out` high from next cycle, FIFO contents discarded.
- `out` is registered, glitch-free.

## Timing

- Word pushed into empty FIFO with transmitter idle on edge E: popped at E+1, `out` falls after edge E+2 (2-cycle latency).
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- Consecutive frames: start bit follows last stop-bit cycle immediately.
- `tx_ready` falls the cycle after the push that fills the FIFO; rises the cycle after a pop from full.
- Effective buffering = FIFO_DEPTH + 1 (one word in shift register).

## Structure

- Package `uart_pkg`: parity-mode constants (NONE/ODD/EVEN), state enum, `DIV` check function.
- Sub-module `sync_fifo` (parametrised WIDTH, DEPTH; push/pop/full/empty/level, same `clk`/`rst`).
- Top: FSM, baud counter, bit counter, shift register, parity bit.

## Test plan

- CLK_HZ=38400, BAUD=9600 (DIV=4), 8N1, push 0xA5 → `out`: 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles, 40 cycles total; `busy` high exactly 40 cycles.
- Same word, PARITY=2 → parity bit 0; PARITY=1 → parity bit 1; frame 44 cycles.
- DEPTH=4, `tx_valid` high 6 consecutive cycles from idle → 5 words accepted, `tx_ready` low on 6th; all 5 frames emitted back-to-back, no high gap between stop and next start.
- DIV=1 (CLK_HZ=BAUD=9600), DATA_BITS=7, STOP_BITS=2, push 0x55 → 10-cycle frame 0,1,0,1,0,1,0,1,1,1.
- Assert `rst` for one cycle mid-DATA with 3 words queued → `out`=1 next cycle, `fifo_level`=0, `busy`=0; no further frames.
- Push and pop in same cycle at level 2 → level stays 2, data order preserved.
